// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Two-port round-robin arbiter for one shared memory, with a bounded
//            bus lock and a one-cycle registered read-valid return path.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int LOCK_MAX = 8
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              a_req,
    input  logic              a_we,
    input  logic              a_lock,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,

    input  logic              b_req,
    input  logic              b_we,
    input  logic              b_lock,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,

    output logic [DATA_W-1:0] rdata,

    output logic              mem_enable,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam logic [1:0] S_NONE  = 2'd0;
    localparam logic [1:0] S_OWN_A = 2'd1;
    localparam logic [1:0] S_OWN_B = 2'd2;

    localparam logic       c_PORT_A   = 1'b0;
    localparam logic       c_PORT_B   = 1'b1;
    localparam logic [7:0] c_LOCK_MAX = 8'(LOCK_MAX);

    logic       r_rr_last;
    logic [1:0] r_owner;
    logic [7:0] r_lock_cnt;
    logic [1:0] r_rd_pend;

    logic       w_gnt_a;
    logic       w_gnt_b;
    logic       w_win_lock;
    logic [1:0] w_win_state;
    logic [7:0] w_cnt_inc;
    logic [1:0] w_owner_nxt;
    logic [7:0] w_cnt_nxt;

    // An owner that stops requesting simply falls through to normal arbitration.
    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (!reset) begin
            if (r_owner == S_OWN_A && a_req) begin
                w_gnt_a = 1'b1;
            end else if (r_owner == S_OWN_B && b_req) begin
                w_gnt_b = 1'b1;
            end else if (a_req && b_req) begin
                if (r_rr_last == c_PORT_B) begin
                    w_gnt_a = 1'b1;
                end else begin
                    w_gnt_b = 1'b1;
                end
            end else if (a_req) begin
                w_gnt_a = 1'b1;
            end else if (b_req) begin
                w_gnt_b = 1'b1;
            end
        end
    end

    always_comb begin
        mem_enable       = 1'b0;
        mem_write_enable = 1'b0;
        mem_address      = '0;
        mem_write_data   = '0;
        if (w_gnt_a) begin
            mem_enable       = 1'b1;
            mem_write_enable = a_we;
            mem_address      = a_addr;
            mem_write_data   = a_wdata;
        end else if (w_gnt_b) begin
            mem_enable       = 1'b1;
            mem_write_enable = b_we;
            mem_address      = b_addr;
            mem_write_data   = b_wdata;
        end
    end

    assign w_win_lock  = (w_gnt_a & a_lock) | (w_gnt_b & b_lock);
    assign w_win_state = w_gnt_a ? S_OWN_A : S_OWN_B;
    assign w_cnt_inc   = (r_owner == w_win_state) ? (r_lock_cnt + 8'd1) : 8'd1;

    // Reaching the hold limit releases immediately; rr_last then points at the
    // releasing port so the other side wins the following contested cycle.
    always_comb begin
        w_owner_nxt = S_NONE;
        w_cnt_nxt   = 8'd0;
        if (w_win_lock && (w_cnt_inc < c_LOCK_MAX)) begin
            w_owner_nxt = w_win_state;
            w_cnt_nxt   = w_cnt_inc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_last  <= c_PORT_B;
            r_owner    <= S_NONE;
            r_lock_cnt <= 8'd0;
            r_rd_pend  <= 2'b00;
        end else begin
            if (w_gnt_a) begin
                r_rr_last <= c_PORT_A;
            end else if (w_gnt_b) begin
                r_rr_last <= c_PORT_B;
            end
            r_owner    <= w_owner_nxt;
            r_lock_cnt <= w_cnt_nxt;
            r_rd_pend  <= {w_gnt_b & ~b_we, w_gnt_a & ~a_we};
        end
    end

    assign a_gnt    = w_gnt_a;
    assign b_gnt    = w_gnt_b;
    assign a_rvalid = r_rd_pend[0] & ~reset;
    assign b_rvalid = r_rd_pend[1] & ~reset;
    assign rdata    = mem_read_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Scoreboard bench for mem_port_arbiter: directed scenarios plus
//            randomized traffic checked against a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int LM = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          a_req = 1'b0, a_we = 1'b0, a_lock = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic          b_req = 1'b0, b_we = 1'b0, b_lock = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DW-1:0] rdata;
    logic          mem_enable, mem_write_enable;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data;
    logic [DW-1:0] mem_read_data;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_gnt(a_gnt), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_gnt(b_gnt), .b_rvalid(b_rvalid),
        .rdata(rdata),
        .mem_enable(mem_enable), .mem_write_enable(mem_write_enable),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] init_val(input int i);
        return (i == 5) ? 16'h1234 : 16'((i * 16'h0101) ^ 16'h5A3C);
    endfunction

    // Synchronous-read memory standing behind the arbiter
    logic [DW-1:0] mem [256];
    logic [DW-1:0] mem_q;
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else if (mem_enable) begin
            if (mem_write_enable) mem[mem_address] <= mem_write_data;
            mem_q <= mem[mem_address];
        end
    end
    assign mem_read_data = mem_q;

    typedef struct {
        logic [1:0]    gnt;
        logic          men;
        logic          mwe;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [1:0]    rv;
    } exp_t;

    typedef struct {
        int            port;
        logic [DW-1:0] data;
    } rd_t;

    exp_t exp_q[$];
    rd_t  rd_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level reference state
    int            m_holder;
    int            m_held;
    int            m_last;
    int            m_win;
    bit            m_pv[2];
    logic [DW-1:0] m_pd[2];
    logic [DW-1:0] ref_mem [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit rst,
                         input bit ar, input bit aw, input bit al,
                         input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input bit br, input bit bw, input bit bl,
                         input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        bit            rq[2], we[2], lk[2];
        logic [AW-1:0] adr[2];
        logic [DW-1:0] wd[2];
        exp_t          e;
        int            w;
        reset = rst;
        a_req = ar; a_we = aw; a_lock = al; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_lock = bl; b_addr = ba; b_wdata = bd;
        rq  = '{ar, br}; we = '{aw, bw}; lk = '{al, bl};
        adr = '{aa, ba}; wd = '{ad, bd};

        w    = -1;
        e.rv = 2'b00;
        if (!rst) begin
            for (int p = 0; p < 2; p++) begin
                if (m_pv[p]) begin
                    e.rv[p] = 1'b1;
                    rd_q.push_back('{port: p, data: m_pd[p]});
                end
            end
            if (m_holder >= 0 && rq[m_holder]) w = m_holder;
            else if (rq[0] && rq[1])           w = 1 - m_last;
            else if (rq[0])                    w = 0;
            else if (rq[1])                    w = 1;
        end
        e.gnt  = (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00;
        e.men  = (w >= 0);
        e.mwe  = (w >= 0) ? we[w] : 1'b0;
        e.addr = (w >= 0) ? adr[w] : '0;
        e.wd   = (w >= 0) ? wd[w] : '0;
        exp_q.push_back(e);

        m_pv = '{0, 0};
        if (rst) begin
            m_holder = -1; m_held = 0; m_last = 1;
            for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        end else if (w >= 0) begin
            m_last = w;
            if (we[w]) ref_mem[adr[w]] = wd[w];
            else begin
                m_pv[w] = 1'b1;
                m_pd[w] = ref_mem[adr[w]];
            end
            if (lk[w]) begin
                m_held   = (m_holder == w) ? m_held + 1 : 1;
                m_holder = (m_held >= LM) ? -1 : w;
                if (m_held >= LM) m_held = 0;
            end else begin
                m_holder = -1; m_held = 0;
            end
        end else begin
            m_holder = -1; m_held = 0;
        end
        m_win = w;
        @(posedge clock);
        #2;
    endtask

    task automatic idle(input bit rst);
        drive(rst, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    endtask

    // Monitor: compares each sampled cycle against the next queued expectation
    initial begin
        exp_t e;
        rd_t  r;
        forever begin
            @(negedge clock);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("grant", 32'({b_gnt, a_gnt}), 32'(e.gnt));
                chk("mem_enable", 32'(mem_enable), 32'(e.men));
                chk("mem_write_enable", 32'(mem_write_enable), 32'(e.mwe));
                chk("mem_address", 32'(mem_address), 32'(e.addr));
                chk("mem_write_data", 32'(mem_write_data), 32'(e.wd));
                chk("rvalid", 32'({b_rvalid, a_rvalid}), 32'(e.rv));
                if (a_rvalid || b_rvalid) begin
                    if (rd_q.size() == 0) begin
                        chk("rd_queue_depth", 32'(rd_q.size()), 32'd1);
                    end else begin
                        r = rd_q.pop_front();
                        chk("rdata_port", 32'({b_rvalid, a_rvalid}),
                            (r.port == 1) ? 32'd2 : 32'd1);
                        chk("rdata", 32'(rdata), 32'(r.data));
                    end
                end else if (e.rv != 2'b00 && rd_q.size() != 0) begin
                    void'(rd_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            pv[2], pwe[2], plk[2];
        logic [AW-1:0] pad[2];
        logic [DW-1:0] pwd[2];
        bit            rst;
        m_holder = -1; m_held = 0; m_last = 1; m_win = -1;
        m_pv = '{0, 0};
        @(posedge clock);
        #2;

        // Reset, then A reads 0x05
        idle(1); idle(1);
        drive(0, 1, 0, 0, 8'h05, '0, 0, 0, 0, '0, '0);
        idle(0); idle(0);

        // Both ports read continuously: A,B,A,B,A,B
        idle(1);
        for (int i = 0; i < 6; i++)
            drive(0, 1, 0, 0, 8'(i), '0, 1, 0, 0, 8'(i + 8), '0);
        idle(0); idle(0);

        // B writes 0xBEEF to 0x10, A reads it back
        drive(0, 0, 0, 0, '0, '0, 1, 1, 0, 8'h10, 16'hBEEF);
        drive(0, 1, 0, 0, 8'h10, '0, 0, 0, 0, '0, '0);
        idle(0); idle(0);

        // B lock with A contending; A waits LOCK_MAX grants
        idle(1);
        drive(0, 0, 0, 0, '0, '0, 1, 0, 1, 8'h20, '0);
        for (int i = 0; i < 4; i++)
            drive(0, 1, 0, 0, 8'h21, '0, 1, 0, 1, 8'(8'h22 + i), '0);
        for (int i = 0; i < 4; i++)
            drive(0, 1, 0, 0, 8'(8'h30 + i), '0, 1, 0, 1, 8'(8'h40 + i), '0);
        idle(0); idle(0);

        // A owner drops req while B requests
        idle(1);
        drive(0, 1, 0, 1, 8'h03, '0, 0, 0, 0, '0, '0);
        drive(0, 0, 0, 0, '0, '0, 1, 0, 0, 8'h04, '0);
        drive(0, 1, 0, 0, 8'h05, '0, 1, 0, 0, 8'h06, '0);
        idle(0); idle(0);

        // Reset right after an A read grant
        idle(1);
        drive(0, 1, 0, 0, 8'h07, '0, 0, 0, 0, '0, '0);
        drive(1, 1, 0, 0, 8'h08, '0, 1, 0, 0, 8'h09, '0);
        drive(0, 1, 0, 0, 8'h08, '0, 1, 0, 0, 8'h09, '0);
        idle(0); idle(0);

        // Randomized traffic honouring the hold-until-grant handshake
        pv = '{0, 0};
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 79) == 0);
            for (int p = 0; p < 2; p++) begin
                if (!pv[p] && $urandom_range(0, 3) != 0) begin
                    pv[p]  = 1'b1;
                    pwe[p] = ($urandom_range(0, 2) == 0);
                    plk[p] = ($urandom_range(0, 1) == 1);
                    pad[p] = 8'($urandom_range(0, 15));
                    pwd[p] = 16'($urandom);
                end
            end
            drive(rst, pv[0], pwe[0], plk[0], pad[0], pwd[0],
                       pv[1], pwe[1], plk[1], pad[1], pwd[1]);
            if (rst) pv = '{0, 0};
            else if (m_win >= 0) pv[m_win] = 1'b0;
        end
        idle(0); idle(0); idle(0);
        repeat (2) @(negedge clock);
        #1;
        chk("scoreboard_drain", 32'(exp_q.size() + rd_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter for the single shared system memory. Port A is the CPU fetch/execute path; port B is a secondary master such as a program loader, DMA or debug port. The block grants one memory transaction per clock using round-robin priority, with an optional bounded bus lock for atomic sequences. It returns read data with a one-cycle registered read-valid to the requester that issued the read.

## Interface
- ADDR_W, 8, memory address width
- DATA_W, 16, memory data width
- LOCK_MAX, 8, maximum consecutive granted cycles a locking requester may hold the bus (1..255)

- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- a_req  in  1  port A requests a transaction this cycle
- a_we  in  1  port A: 1 = write, 0 = read
- a_lock  in  1  port A requests to retain ownership after this transaction
- a_addr  in  ADDR_W  port A address
- a_wdata  in  DATA_W  port A write data
- a_gnt  out  1  port A transaction issued to memory this cycle
- a_rvalid  out  1  port A read data valid (registered)
- b_req, b_we, b_lock, b_addr, b_wdata, b_gnt, b_rvalid  same as port A, for port B
- rdata  out  DATA_W  read data, shared by both ports; qualified by a_rvalid or b_rvalid
- mem_enable  out  1  memory access active
- mem_write_enable  out  1  memory write strobe
- mem_address  out  ADDR_W  memory address
- mem_write_data  out  DATA_W  memory write data
- mem_read_data  in  DATA_W  memory read data, valid one cycle after the address is presented

## Operation
- State:
  - rr_last (1 bit): last granted port.
  - owner: NONE, A or B.
  - lock_cnt (8 bits).
  - rd_pend (2 bits): one-hot {B,A}, read issued last cycle.
- Arbitration, combinational each cycle:
  - If owner is A or B and that owner's req = 1, the owner wins regardless of the other port.
  - Else, if only one port requests, it wins.
  - Else, if both request, the port not equal to rr_last wins.
  - Else, no grant.
- Exactly one of a_gnt and b_gnt is high, or neither. Both high is illegal.
- Memory mux follows the winner:
  - mem_address, mem_write_data and mem_write_enable come from the winner's addr, wdata and we.
  - mem_enable is 1 when there is a winner.
  - With no winner, mem_enable = 0, mem_write_enable = 0, and address and write data are 0.
- Handshake:
  - A requester holds req, we, addr, wdata and lock stable until it sees gnt.
  - The transaction completes in the gnt cycle.
  - The requester may change inputs in the cycle after gnt.
- Read return:
  - A granted read sets the matching rd_pend bit for the next cycle.
  - In that next cycle, a_rvalid / b_rvalid = rd_pend, and rdata = mem_read_data, passed through combinationally in the rvalid cycle.
  - Writes produce no rvalid.
- Ownership FSM (NONE / OWN_A / OWN_B):
  - NONE -> OWN_x when x is granted with x_lock = 1. lock_cnt is set to 1.
  - OWN_x, x granted with x_lock = 1 and lock_cnt < LOCK_MAX: stay in OWN_x, lock_cnt increments.
  - OWN_x -> NONE when x is granted with x_lock = 0, when x_req = 0, or when lock_cnt reaches LOCK_MAX. lock_cnt is cleared.
  - On forced release at LOCK_MAX, rr_last = x. The other port wins the next cycle if it is requesting.
- rr_last updates to the granted port on every grant.

## Timing
- Reset values:
  - rr_last = B, so A wins the first contested cycle.
  - owner = NONE, lock_cnt = 0, rd_pend = 0.
  - a_rvalid = b_rvalid = 0, rdata = mem_read_data (don't-care while rvalid = 0).
- Grant latency: 0 cycles. gnt is asserted in the same cycle as req when the port wins.
- Read latency: exactly 1 cycle from gnt to rvalid.
- Throughput: one transaction per cycle. Back-to-back reads from alternating ports give alternating rvalids.
- Contention: with both ports continuously requesting and no lock, grants alternate A, B, A, B…
- Worst-case wait for a non-locking requester is LOCK_MAX + 1 cycles.
- Reset asserted mid-operation:
  - Pending rvalid is dropped and ownership is released.
  - In the reset cycle itself, gnt outputs and mem_enable are forced to 0.
- A port that drops req while it is owner releases ownership that same cycle. The other port may be granted in that cycle.

## Test plan
- Reset then A read of addr 0x05, where memory 0x05 = 0x1234: a_gnt high in cycle 0, a_rvalid high and rdata = 0x1234 in cycle 1, b signals 0.
- Both ports request reads every cycle for 6 cycles, starting from reset: grants A, B, A, B, A, B, and rvalids follow one cycle later in the same order.
- B writes 0xBEEF to 0x10 while A idle, then A reads 0x10: mem_write_enable high for exactly one cycle, and A receives 0xBEEF.
- LOCK_MAX = 4, B holds lock with continuous req while A also requests: B is granted 4 consecutive cycles, A is granted on the 5th, and B regains the bus afterwards only via round-robin.
- A owner with a_lock = 1 drops a_req while b_req = 1: b_gnt is asserted in that same cycle, and owner returns to NONE.
- Reset asserted the cycle after an A read grant: a_rvalid stays 0, owner = NONE, and the next contested cycle grants A.
